// File: rtl/clk_gate_idle_ctrl_if.sv
// Bundle between a gated clock branch and its always-on idle controller.
//   busy      : domain has work in flight (level)
//   wake_req  : requester needs the clock; held until clk_rdy is seen
//   force_on  : debug override, keeps the clock running
//   en        : registered enable to the clock-gate cell
//   clk_rdy   : clock running and settled
//   gated     : clock currently gated
//   gate_evts : saturating count of RUN->GATED transitions
// master = the domain side, slave = the controller.
interface clk_gate_idle_ctrl_if #(
  parameter int EVT_W = 16
);
  logic             busy;
  logic             wake_req;
  logic             force_on;
  logic             en;
  logic             clk_rdy;
  logic             gated;
  logic [EVT_W-1:0] gate_evts;

  modport master (
    output busy, wake_req, force_on,
    input  en, clk_rdy, gated, gate_evts
  );

  modport slave (
    input  busy, wake_req, force_on,
    output en, clk_rdy, gated, gate_evts
  );
endinterface

// File: rtl/clk_gate_idle_ctrl.sv
// Idle-driven clock-gate enable controller, one per gated clock branch,
// living in the always-on domain.
// Gates the branch after IDLE_CYCLES consecutive idle samples, ungates on
// any activity, then holds clk_rdy low for a WAKE_CYCLES settle window.
// Ports:
//   clk : free-running (ungated) clock
//   rst : synchronous reset, active-high
//   bus : clk_gate_idle_ctrl_if.slave (busy/wake_req/force_on in,
//         en/clk_rdy/gated/gate_evts out)
// The interface EVT_W must match this module's EVT_W.
module clk_gate_idle_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int EVT_W       = 16
) (
  input logic                 clk,
  input logic                 rst,
  clk_gate_idle_ctrl_if.slave bus
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [WW-1:0]    wake_cnt_q, wake_cnt_d;
  logic [EVT_W-1:0] gate_evts_q, gate_evts_d;
  logic             en_q, en_d;
  logic             clk_rdy_q, clk_rdy_d;
  logic             gated_q, gated_d;
  logic             idle;

  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (&v) ? v : v + EVT_W'(1);
  endfunction

  assign idle = !bus.busy && !bus.wake_req && !bus.force_on;

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    wake_cnt_d  = wake_cnt_q;
    gate_evts_d = gate_evts_q;
    unique case (state_q)
      ST_RUN: begin
        if (!idle) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IW'(IDLE_CYCLES - 1)) begin
          state_d     = ST_GATED;
          idle_cnt_d  = '0;
          gate_evts_d = sat_inc(gate_evts_q);
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      ST_GATED: begin
        if (!idle) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        // The settle window always runs to completion, even if idle returns.
        if (wake_cnt_q == WW'(WAKE_CYCLES - 1)) begin
          state_d    = ST_RUN;
          idle_cnt_d = '0;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WW'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it;
    // en leaves straight from a flop with no input-to-en combinational path.
    en_d      = (state_d != ST_GATED);
    clk_rdy_d = (state_d == ST_RUN);
    gated_d   = (state_d == ST_GATED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      gate_evts_q <= '0;
      en_q        <= 1'b1;
      clk_rdy_q   <= 1'b1;
      gated_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      gate_evts_q <= gate_evts_d;
      en_q        <= en_d;
      clk_rdy_q   <= clk_rdy_d;
      gated_q     <= gated_d;
    end
  end

  assign bus.en        = en_q;
  assign bus.clk_rdy   = clk_rdy_q;
  assign bus.gated     = gated_q;
  assign bus.gate_evts = gate_evts_q;

endmodule

// File: tb/tb_clk_gate_idle_ctrl.sv
// Bench for clk_gate_idle_ctrl: three instances share one stimulus stream
//   u0: IDLE=4 WAKE=2 EVT_W=16 (main configuration)
//   u1: IDLE=4 WAKE=2 EVT_W=2  (event counter saturation)
//   u2: IDLE=1 WAKE=1 EVT_W=16 (single-sample gating)
// A behavioural model tracks idle run length, gating and remaining settle
// cycles per instance; literal expectations pin the model on instance u0/u1.
module tb_clk_gate_idle_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clk_gate_idle_ctrl_if #(.EVT_W(16)) if0 ();
  clk_gate_idle_ctrl_if #(.EVT_W(2))  if1 ();
  clk_gate_idle_ctrl_if #(.EVT_W(16)) if2 ();

  clk_gate_idle_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .EVT_W(16))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  clk_gate_idle_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .EVT_W(2))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  clk_gate_idle_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1), .EVT_W(16))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  logic busy, wake_req, force_on;
  assign if0.busy = busy; assign if0.wake_req = wake_req; assign if0.force_on = force_on;
  assign if1.busy = busy; assign if1.wake_req = wake_req; assign if1.force_on = force_on;
  assign if2.busy = busy; assign if2.wake_req = wake_req; assign if2.force_on = force_on;

  logic        act_en [3];
  logic        act_rdy[3];
  logic        act_gt [3];
  logic [31:0] act_ev [3];
  assign act_en[0] = if0.en;      assign act_rdy[0] = if0.clk_rdy;
  assign act_en[1] = if1.en;      assign act_rdy[1] = if1.clk_rdy;
  assign act_en[2] = if2.en;      assign act_rdy[2] = if2.clk_rdy;
  assign act_gt[0] = if0.gated;   assign act_ev[0] = {16'd0, if0.gate_evts};
  assign act_gt[1] = if1.gated;   assign act_ev[1] = {30'd0, if1.gate_evts};
  assign act_gt[2] = if2.gated;   assign act_ev[2] = {16'd0, if2.gate_evts};

  int idle_thr[3] = '{4, 4, 1};
  int wake_thr[3] = '{2, 2, 1};
  int ev_max  [3] = '{65535, 3, 65535};

  // Model: clock is gated or not; if ungating, how many settle cycles remain.
  bit m_gated    [3];
  int m_wake_left[3];
  int m_idle_run [3];
  int m_evts     [3];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic b, input logic w, input logic f);
    busy = b; wake_req = w; force_on = f;
  endtask

  task automatic model_step();
    bit idle;
    idle = !busy && !wake_req && !force_on;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_gated[i] = 0; m_wake_left[i] = 0; m_idle_run[i] = 0; m_evts[i] = 0;
      end else if (m_wake_left[i] > 0) begin
        m_wake_left[i]--;
        if (m_wake_left[i] == 0) m_idle_run[i] = 0;
      end else if (m_gated[i]) begin
        if (!idle) begin
          m_gated[i] = 0;
          m_wake_left[i] = wake_thr[i];
        end
      end else if (!idle) begin
        m_idle_run[i] = 0;
      end else begin
        m_idle_run[i]++;
        if (m_idle_run[i] == idle_thr[i]) begin
          m_gated[i] = 1;
          m_idle_run[i] = 0;
          m_evts[i]++;
        end
      end
    end
  endtask

  // One clock: model samples the same inputs as the DUT at the edge,
  // outputs are compared on the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.en", i),      {31'd0, act_en[i]},  {31'd0, !m_gated[i]});
      chk($sformatf("u%0d.clk_rdy", i), {31'd0, act_rdy[i]}, {31'd0, (!m_gated[i] && m_wake_left[i] == 0)});
      chk($sformatf("u%0d.gated", i),   {31'd0, act_gt[i]},  {31'd0, m_gated[i]});
      chk($sformatf("u%0d.gate_evts", i), act_ev[i],
          (m_evts[i] > ev_max[i]) ? ev_max[i] : m_evts[i]);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0);
    tick();
    chk("rst_en", {31'd0, if0.en}, 32'd1);
    chk("rst_clk_rdy", {31'd0, if0.clk_rdy}, 32'd1);
    chk("rst_gated", {31'd0, if0.gated}, 32'd0);
    chk("rst_evts", {16'd0, if0.gate_evts}, 32'd0);
    rst = 1'b0;

    // Plain idle run from reset.
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_en_hold", {31'd0, if0.en}, 32'd1);
      if (k == 1) chk("t1_idle1_gated", {31'd0, if2.gated}, 32'd1);
    end
    tick();
    chk("t1_en_fall", {31'd0, if0.en}, 32'd0);
    chk("t1_gated", {31'd0, if0.gated}, 32'd1);
    chk("t1_evts", {16'd0, if0.gate_evts}, 32'd1);

    // Wake request from GATED, then regate.
    set_in(0, 1, 0);
    tick();
    chk("t3_en_rise", {31'd0, if0.en}, 32'd1);
    chk("t3_rdy_n", {31'd0, if0.clk_rdy}, 32'd0);
    tick();
    chk("t3_rdy_n1", {31'd0, if0.clk_rdy}, 32'd0);
    tick();
    chk("t3_rdy_n2", {31'd0, if0.clk_rdy}, 32'd1);
    set_in(0, 0, 0);
    repeat (3) begin
      tick();
      chk("t3_en_hold", {31'd0, if0.en}, 32'd1);
    end
    tick();
    chk("t3_regate", {31'd0, if0.en}, 32'd0);
    chk("t3_evts", {16'd0, if0.gate_evts}, 32'd2);

    // Idle run interrupted by one busy cycle restarts the count.
    set_in(0, 1, 0);
    repeat (3) tick();
    set_in(0, 0, 0);
    repeat (3) tick();
    set_in(1, 0, 0);
    tick();
    set_in(0, 0, 0);
    repeat (3) begin
      tick();
      chk("t2_en_hold", {31'd0, if0.en}, 32'd1);
    end
    tick();
    chk("t2_en_fall", {31'd0, if0.en}, 32'd0);
    chk("t2_evts", {16'd0, if0.gate_evts}, 32'd3);

    // force_on wakes from GATED, then holds RUN.
    set_in(0, 0, 1);
    repeat (3) tick();
    chk("t4_rdy", {31'd0, if0.clk_rdy}, 32'd1);
    repeat (100) begin
      tick();
      chk("t4_en", {31'd0, if0.en}, 32'd1);
      chk("t4_rdy_hold", {31'd0, if0.clk_rdy}, 32'd1);
    end
    chk("t4_evts", {16'd0, if0.gate_evts}, 32'd3);
    set_in(0, 0, 0);
    repeat (4) tick();
    chk("t4_evts_after", {16'd0, if0.gate_evts}, 32'd4);
    chk("t6_sat_a", {30'd0, if1.gate_evts}, 32'd3);

    // More gate/wake cycles: narrow counter stays saturated.
    repeat (2) begin
      set_in(1, 0, 0);
      repeat (3) tick();
      set_in(0, 0, 0);
      repeat (4) tick();
    end
    chk("t6_evts_wide", {16'd0, if0.gate_evts}, 32'd6);
    chk("t6_sat_b", {30'd0, if1.gate_evts}, 32'd3);

    // Reset in the middle of the settle window.
    set_in(0, 1, 0);
    tick();
    chk("t5_in_wake", {31'd0, if0.clk_rdy}, 32'd0);
    rst = 1'b1;
    tick();
    chk("t5_en", {31'd0, if0.en}, 32'd1);
    chk("t5_rdy", {31'd0, if0.clk_rdy}, 32'd1);
    chk("t5_gated", {31'd0, if0.gated}, 32'd0);
    chk("t5_evts", {16'd0, if0.gate_evts}, 32'd0);
    chk("t5_evts_narrow", {30'd0, if1.gate_evts}, 32'd0);
    rst = 1'b0;
    set_in(0, 0, 0);
    repeat (4) tick();
    chk("t5_regate", {31'd0, if0.gated}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
